// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier scheduler.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_t;

   localparam int OP_W        = 8;
   localparam int PROD_W      = 16;
   localparam int DEF_TIMEOUT = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id
);

   logic found;
   int   idx;

   // First requester found after ptr wins; nothing is granted while disabled.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mult_sched.sv
// Shares one sequential 8x8 multiplier among N_REQ requesters.
//
//   state | meaning
//   IDLE  | arbitrate, accept one operand pair
//   ISSUE | one-cycle start pulse, load timeout counter
//   WAIT  | wait for mult_done or timeout
//   RESP  | hold response until rsp_ready
module mult_sched
   import mult_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ID_W    = $clog2(N_REQ),
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset_a,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*OP_W-1:0]   req_a,
   input  logic [N_REQ*OP_W-1:0]   req_b,
   output logic                    mult_start,
   output logic [OP_W-1:0]         mult_dataa,
   output logic [OP_W-1:0]         mult_datab,
   input  logic                    mult_done,
   input  logic [PROD_W-1:0]       mult_product,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [PROD_W-1:0]       rsp_product,
   output logic                    rsp_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [OP_W-1:0]     a_q, a_d;
   logic [OP_W-1:0]     b_q, b_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PROD_W-1:0]   prod_q, prod_d;
   logic                err_q, err_d;

   logic [N_REQ-1:0]    grant;
   logic [ID_W-1:0]     grant_id;
   logic [OP_W-1:0]     a_sel, b_sel;
   logic                arb_en;

   // Grants only in IDLE; reset also masks grants so req_ready clears at once.
   assign arb_en = (state_q == IDLE) && !reset_a;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req      (req_valid),
      .ptr      (ptr_q),
      .en       (arb_en),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // One-hot operand mux driven by the grant.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            a_sel = a_sel | req_a[i*OP_W +: OP_W];
            b_sel = b_sel | req_b[i*OP_W +: OP_W];
         end
      end
   end

   // Next-state, register updates and handshake outputs.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      a_d        = a_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      err_d      = err_q;
      mult_start = 1'b0;
      rsp_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|(req_valid & grant)) begin
               a_d     = a_sel;
               b_d     = b_sel;
               id_d    = grant_id;
               ptr_d   = grant_id;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mult_start = 1'b1;
            cnt_d      = CNT_W'(TIMEOUT);
            state_d    = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // A done pulse in the terminal-count cycle still counts as success.
            if (mult_done) begin
               prod_d  = mult_product;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q <= CNT_W'(1)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         state_q <= IDLE;
         ptr_q   <= ID_W'(N_REQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         err_q   <= err_d;
      end
   end

   assign req_ready   = grant;
   assign mult_dataa  = a_q;
   assign mult_datab  = b_q;
   assign rsp_id      = id_q;
   assign rsp_product = prod_q;
   assign rsp_err     = err_q;

endmodule

// File: doc/mult_sched.md
# mult_sched

Round-robin scheduler that shares one sequential 8x8 multiplier among `N_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and pulses the multiplier's `start`. It then waits for `done` (with a timeout) and returns the 16-bit product, tagged with the requester index, over a response handshake. It sits between client blocks and the multiplier top (control FSM plus datapath).

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, 2, requester-index width, equal to clog2(`N_REQ`)
- `TIMEOUT`, 12, cycles allowed from the start pulse to `mult_done` before an error response

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `reset_a`  in  1  reset, asynchronous, active-high
- `req_valid`  in  `N_REQ`  per-requester request valid
- `req_ready`  out  `N_REQ`  per-requester accept; at most one bit high
- `req_a`  in  `N_REQ`*8  packed operand A; requester i is at bits [8i+7:8i]
- `req_b`  in  `N_REQ`*8  packed operand B; same packing as `req_a`
- `mult_start`  out  1  one-cycle start pulse to the multiplier
- `mult_dataa`  out  8  registered operand A to the multiplier
- `mult_datab`  out  8  registered operand B to the multiplier
- `mult_done`  in  1  multiplier completion, one-cycle pulse
- `mult_product`  in  16  multiplier result, valid in the cycle `mult_done` is high
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  `ID_W`  index of the requester that owns the response
- `rsp_product`  out  16  product; 0 when `rsp_err` is high
- `rsp_err`  out  1  timeout flag for this response

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - `req_ready[g]`=1 only for the round-robin winner g; the value is combinational from `req_valid` and the pointer.
  - On `req_valid[g]`&`req_ready[g]`: latch `req_a[g]` and `req_b[g]` into the operand registers, latch g into the id register, set `ptr`=g, go to ISSUE.
  - With no request valid: stay in IDLE, all `req_ready`=0.
- Round-robin arbitration: search starts at `ptr`+1 and wraps modulo `N_REQ`. The pointer updates only on acceptance.
- ISSUE
  - `mult_start`=1 for exactly one cycle; load the timeout counter with `TIMEOUT`; go to WAIT.
  - `start` is never held high for two cycles; the multiplier control treats `start` high mid-sequence as an error.
- WAIT
  - Count the timeout counter down.
  - If `mult_done`=1: capture `mult_product`, clear the error flag, go to RESP.
  - Else, if the counter reaches 0: set product=0 and `rsp_err`=1, go to RESP.
  - If `mult_done` arrives in the same cycle the counter reaches 0, `mult_done` wins.
- RESP
  - Drive `rsp_valid`=1 with `rsp_id`, `rsp_product` and `rsp_err` stable until `rsp_ready`=1, then go to IDLE.
  - `req_ready` stays all 0 in ISSUE, WAIT and RESP.
- `mult_done` arriving outside WAIT is ignored and never produces a response.
- `mult_dataa` and `mult_datab` hold the latched operands from ISSUE through RESP. They are updated only on acceptance.
- Arithmetic: the product is taken unmodified from the multiplier; the block does no width conversion. The timeout counter is clog2(`TIMEOUT`+1) bits.

## Timing
- Reset values:
  - state=IDLE, `ptr`=`N_REQ`-1, so requester 0 has first priority.
  - All outputs 0: `req_ready`, `mult_start`, `mult_dataa`, `mult_datab`, `rsp_valid`, `rsp_id`, `rsp_product`, `rsp_err`.
- Latency from acceptance at cycle T:
  - `mult_start` is high in cycle T+1.
  - For `mult_done` at cycle D, `rsp_valid` rises at D+1.
  - With the nominal 5-cycle multiplier, the response appears at T+7.
- Back-to-back: after `rsp_ready` at cycle R, the next acceptance is possible at R+1. Minimum issue interval = multiplier latency + 3 cycles.
- Timeout: with no `mult_done`, `rsp_valid` rises `TIMEOUT`+1 cycles after the `mult_start` cycle.
- Reset mid-operation: outputs clear asynchronously, the pending request is dropped with no response, and the pointer returns to `N_REQ`-1.

## Structure
- Package `mult_pkg` holds:
  - the state encoding IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11;
  - constants for operand width 8 and product width 16;
  - the default `TIMEOUT`.
- Sub-module `rr_arbiter` (parameter `N_REQ`): inputs `req`, `ptr` and `en`; outputs a one-hot `grant` and a binary `grant_id`; purely combinational. `mult_sched` holds the FSM, the registers and the timeout counter.

## Test plan
- Single request: after reset, requester 1 sends a=8'd13, b=8'd11; the model asserts `mult_done` 5 cycles after start with 16'd143 → response `rsp_id`=1, `rsp_product`=16'd143, `rsp_err`=0 at T+7; `mult_start` high for exactly one cycle.
- Fairness: all 4 requesters held valid → grant order 0,1,2,3,0. Only one `req_ready` bit is ever high, and it is high only in IDLE.
- Back-pressure: `rsp_ready` held 0 for 6 cycles → `rsp_valid`, `rsp_id` and `rsp_product` stay stable; no new `req_ready` until the cycle after `rsp_ready`=1.
- Timeout: the model never asserts `mult_done` → `rsp_err`=1, `rsp_product`=0, `rsp_valid` at `mult_start`+13 cycles (`TIMEOUT`=12). A `mult_done` pulse injected later in IDLE yields no response.
- Done-vs-timeout tie: `mult_done` in the same cycle the counter reaches 0 → `rsp_err`=0 and the real product is returned.
- Reset mid-WAIT: `reset_a` pulsed 2 cycles after start → all outputs are 0 immediately. The next request, from requester 3 with requester 0 also valid, goes to requester 0 first.
